operand_net_iface: RTL and testbench

- Network interface between one E-tile's operand port and the local port of its operand-network router.
- Injection path: accepts operands (data, dest instr, slot, block ID), packs them into flits and queues them for the router local port.
- Ejection path: unpacks flits arriving from the router and delivers them to the E-tile.
- Local bypass: operands whose target is this tile skip the network entirely.

---
 rtl/operand_net_iface_pkg.sv | 49 ++++
 rtl/operand_net_iface_sync_fifo.sv | 58 +++++
 rtl/operand_net_iface.sv | 117 +++++++++++
 tb/tb_operand_net_iface.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/operand_net_iface_pkg.sv
// operand_net_iface_pkg: shared operand-network types, field widths and header helpers.
//   operand_hdr_t   : routing header {dst_row, dst_col, slot, frame}
//   operand_flit_t  : full flit at the default 3-bit block ID / 32-bit data widths
//   instr_to_hdr()  : split a 7-bit instruction number plus slot into a header
//   hdr_to_instr()  : rebuild the 7-bit instruction number from a header
package operand_net_iface_pkg;

    localparam int ET_GRID_DIM = 4;
    localparam int COORD_W     = $clog2(ET_GRID_DIM);
    localparam int SLOT_W      = 2;
    localparam int FRAME_W     = 3;
    localparam int INSTR_W     = 2 * COORD_W + FRAME_W;
    localparam int HDR_W       = 2 * COORD_W + SLOT_W + FRAME_W;

    localparam logic [SLOT_W-1:0] SLOT_LEFT  = 2'd0;
    localparam logic [SLOT_W-1:0] SLOT_RIGHT = 2'd1;
    localparam logic [SLOT_W-1:0] SLOT_PRED  = 2'd2;

    localparam int DEF_BID_W  = 3;
    localparam int DEF_DATA_W = 32;

    typedef struct packed {
        logic [COORD_W-1:0] dst_row;
        logic [COORD_W-1:0] dst_col;
        logic [SLOT_W-1:0]  slot;
        logic [FRAME_W-1:0] frame;
    } operand_hdr_t;

    typedef struct packed {
        operand_hdr_t          hdr;
        logic [DEF_BID_W-1:0]  block_id;
        logic [DEF_DATA_W-1:0] data;
    } operand_flit_t;

    typedef enum logic {
        PRIO_NET = 1'b0,
        PRIO_BYP = 1'b1
    } arb_prio_e;

    function automatic operand_hdr_t instr_to_hdr(input logic [INSTR_W-1:0] instr,
                                                  input logic [SLOT_W-1:0] slot);
        return '{dst_row: instr[6:5], dst_col: instr[4:3], slot: slot, frame: instr[2:0]};
    endfunction

    function automatic logic [INSTR_W-1:0] hdr_to_instr(input operand_hdr_t hdr);
        return {hdr.dst_row, hdr.dst_col, hdr.frame};
    endfunction

endpackage

// File: rtl/operand_net_iface_sync_fifo.sv
// operand_sync_fifo: register-based synchronous FIFO with conservative full flag.
//   clk, rst_n : clock, asynchronous active-low reset (empties the FIFO)
//   push, din  : write request and data (ignored when full)
//   pop        : read request (ignored when empty)
//   full/empty : occupancy flags from the registered count
//   head       : oldest entry, forced to zero while empty
module operand_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    rd_q, rd_d, wr_q, wr_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full  = cnt_q == FULL_CNT;
    assign empty = cnt_q == '0;
    assign head  = empty ? '0 : mem_q[rd_q];

    always_comb begin
        do_push = push && !full;
        do_pop  = pop && !empty;
        mem_d   = mem_q;
        if (do_push) mem_d[wr_q] = din;
        wr_d  = wr_q + AW'(do_push);
        rd_d  = rd_q + AW'(do_pop);
        cnt_d = cnt_q + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '{default: '0};
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/operand_net_iface.sv
// operand_net_iface: E-tile operand port <-> operand-network router local port.
//   inj_*        : operand from the E-tile; remote targets go to the injection FIFO,
//                  local targets bypass into the ejection FIFO
//   net_out_*    : flits from the injection FIFO head to the router
//   net_in_*     : flits from the router; foreign flits are dropped and counted
//   ej_*         : operands from the ejection FIFO head to the E-tile
//   misroute_cnt : saturating count of dropped foreign flits
module operand_net_iface
    import operand_net_iface_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int BID_W     = 3,
    parameter int INJ_DEPTH = 4,
    parameter int EJ_DEPTH  = 4,
    parameter int MY_ROW    = 0,
    parameter int MY_COL    = 0
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            inj_req,
    output logic                            inj_ack,
    input  logic [DATA_W-1:0]               inj_data,
    input  logic [INSTR_W-1:0]              inj_dest_instr,
    input  logic [SLOT_W-1:0]               inj_dest_slot,
    input  logic [BID_W-1:0]                inj_block_id,
    output logic                            net_out_req,
    input  logic                            net_out_ack,
    output logic [HDR_W+BID_W+DATA_W-1:0]   net_out_flit,
    input  logic                            net_in_req,
    output logic                            net_in_ack,
    input  logic [HDR_W+BID_W+DATA_W-1:0]   net_in_flit,
    output logic                            ej_req,
    input  logic                            ej_ack,
    output logic [DATA_W-1:0]               ej_data,
    output logic [INSTR_W-1:0]              ej_dest_instr,
    output logic [SLOT_W-1:0]               ej_dest_slot,
    output logic [BID_W-1:0]                ej_block_id,
    output logic [7:0]                      misroute_cnt
);

    localparam int FLIT_W = HDR_W + BID_W + DATA_W;
    localparam logic [2*COORD_W-1:0] MY_POS = {COORD_W'(MY_ROW), COORD_W'(MY_COL)};

    operand_hdr_t      inj_hdr, ej_hdr;
    arb_prio_e         prio_q, prio_d;
    logic [7:0]        mis_q, mis_d;
    logic [FLIT_W-1:0] inj_flit, ej_din, ej_head;
    logic              inj_local, in_local, byp_req, nin_req, byp_ok, net_ok;
    logic              inj_push, byp_push, net_push, ej_push, ej_pop, misroute;
    logic              inj_full, inj_empty, ej_full, ej_empty;

    always_comb begin
        inj_hdr   = instr_to_hdr(inj_dest_instr, inj_dest_slot);
        inj_local = inj_dest_instr[6:3] == MY_POS;
        in_local  = net_in_flit[FLIT_W-1 -: 2*COORD_W] == MY_POS;
        byp_req   = inj_req && inj_local;
        nin_req   = net_in_req && in_local;
        // A side may take the ejection write port when it holds priority or the other side is idle;
        // neither test looks at that side's own req, so each ack stays free of its own request.
        byp_ok    = prio_q == PRIO_BYP || !nin_req;
        net_ok    = prio_q == PRIO_NET || !byp_req;
        inj_ack    = rst_n && (inj_local ? !ej_full && byp_ok : !inj_full);
        net_in_ack = rst_n && (!in_local || (!ej_full && net_ok));
        inj_push  = inj_req && inj_ack && !inj_local;
        byp_push  = byp_req && inj_ack;
        net_push  = nin_req && net_in_ack;
        misroute  = net_in_req && net_in_ack && !in_local;
        ej_push   = byp_push || net_push;
        ej_pop    = ej_req && ej_ack;
        inj_flit  = {inj_hdr, inj_block_id, inj_data};
        ej_din    = byp_push ? inj_flit : net_in_flit;
        prio_d    = byp_push ? PRIO_NET : net_push ? PRIO_BYP : prio_q;
        mis_d     = misroute && mis_q != 8'hFF ? mis_q + 8'd1 : mis_q;
        ej_hdr    = ej_head[FLIT_W-1 -: HDR_W];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q <= PRIO_NET;
            mis_q  <= '0;
        end else begin
            prio_q <= prio_d;
            mis_q  <= mis_d;
        end
    end

    operand_sync_fifo #(.WIDTH(FLIT_W), .DEPTH(INJ_DEPTH)) u_inj_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (inj_push),
        .pop   (net_out_req && net_out_ack),
        .din   (inj_flit),
        .full  (inj_full),
        .empty (inj_empty),
        .head  (net_out_flit)
    );

    operand_sync_fifo #(.WIDTH(FLIT_W), .DEPTH(EJ_DEPTH)) u_ej_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (ej_push),
        .pop   (ej_pop),
        .din   (ej_din),
        .full  (ej_full),
        .empty (ej_empty),
        .head  (ej_head)
    );

    assign net_out_req   = !inj_empty;
    assign ej_req        = !ej_empty;
    assign ej_data       = ej_head[DATA_W-1:0];
    assign ej_block_id   = ej_head[DATA_W +: BID_W];
    assign ej_dest_slot  = ej_hdr.slot;
    assign ej_dest_instr = hdr_to_instr(ej_hdr);
    assign misroute_cnt  = mis_q;

endmodule

// File: tb/tb_operand_net_iface.sv
// tb_operand_net_iface: directed bench with a queue-based model of tile (1,2).
module tb_operand_net_iface;
    import operand_net_iface_pkg::*;

    localparam int DW = 32;
    localparam int BW = 3;
    localparam int FW = 9 + BW + DW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          inj_req = 1'b0, net_out_ack = 1'b0, net_in_req = 1'b0, ej_ack = 1'b0;
    logic [DW-1:0] inj_data = '0;
    logic [6:0]    inj_dest_instr = '0;
    logic [1:0]    inj_dest_slot = '0;
    logic [BW-1:0] inj_block_id = '0;
    logic [FW-1:0] net_in_flit = '0;
    logic          inj_ack, net_out_req, net_in_ack, ej_req;
    logic [FW-1:0] net_out_flit;
    logic [DW-1:0] ej_data;
    logic [6:0]    ej_dest_instr;
    logic [1:0]    ej_dest_slot;
    logic [BW-1:0] ej_block_id;
    logic [7:0]    misroute_cnt;

    int checks = 0;
    int errors = 0;

    operand_net_iface #(
        .DATA_W(DW), .BID_W(BW), .INJ_DEPTH(4), .EJ_DEPTH(4), .MY_ROW(1), .MY_COL(2)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .inj_req(inj_req), .inj_ack(inj_ack), .inj_data(inj_data),
        .inj_dest_instr(inj_dest_instr), .inj_dest_slot(inj_dest_slot), .inj_block_id(inj_block_id),
        .net_out_req(net_out_req), .net_out_ack(net_out_ack), .net_out_flit(net_out_flit),
        .net_in_req(net_in_req), .net_in_ack(net_in_ack), .net_in_flit(net_in_flit),
        .ej_req(ej_req), .ej_ack(ej_ack), .ej_data(ej_data), .ej_dest_instr(ej_dest_instr),
        .ej_dest_slot(ej_dest_slot), .ej_block_id(ej_block_id), .misroute_cnt(misroute_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [31:0] data;
        logic [6:0]  instr;
        logic [1:0]  slot;
        logic [2:0]  bid;
    } op_t;

    function automatic logic [FW-1:0] pack_flit(input logic [6:0] instr, input logic [1:0] slot,
                                                input logic [2:0] bid, input logic [31:0] data);
        return {instr[6:3], slot, instr[2:0], bid, data};
    endfunction

    function automatic op_t unpack(input logic [FW-1:0] f);
        op_t o;
        o.data  = f[31:0];
        o.bid   = f[34:32];
        o.slot  = f[39:38];
        o.instr = {f[43:40], f[37:35]};
        return o;
    endfunction

    // model: ejection queue, injection queue, network-has-priority flag, misroute count
    op_t           ej_m[$];
    logic [FW-1:0] inj_m[$];
    bit            net_prio = 1'b1;
    int            mis_m = 0;

    initial begin
        bit inj_loc, in_loc, e_ia, e_na, xi, xn, p_ej, p_inj;
        forever begin
            @(negedge clk);
            xi = 0; xn = 0; p_ej = 0; p_inj = 0;
            if (!rst_n) begin
                ej_m.delete();
                inj_m.delete();
                net_prio = 1'b1;
                mis_m = 0;
                chk("rst_inj_ack", inj_ack, 0);
                chk("rst_net_in_ack", net_in_ack, 0);
                chk("rst_net_out_req", net_out_req, 0);
                chk("rst_ej_req", ej_req, 0);
                chk("rst_misroute", misroute_cnt, 0);
            end else begin
                inj_loc = inj_dest_instr[6:3] == 4'b0110;
                in_loc  = net_in_flit[43:40] == 4'b0110;
                e_ia = inj_loc ? (ej_m.size() < 4 && (!net_prio || !(net_in_req && in_loc)))
                               : inj_m.size() < 4;
                e_na = !in_loc || (ej_m.size() < 4 && (net_prio || !(inj_req && inj_loc)));
                chk("m_inj_ack", inj_ack, e_ia);
                chk("m_net_in_ack", net_in_ack, e_na);
                chk("m_net_out_req", net_out_req, inj_m.size() != 0);
                chk("m_ej_req", ej_req, ej_m.size() != 0);
                chk("m_misroute", misroute_cnt, mis_m);
                if (inj_m.size() != 0) chk("m_net_out_flit", net_out_flit, inj_m[0]);
                if (ej_m.size() != 0) begin
                    chk("m_ej_data", ej_data, ej_m[0].data);
                    chk("m_ej_instr", ej_dest_instr, ej_m[0].instr);
                    chk("m_ej_slot", ej_dest_slot, ej_m[0].slot);
                    chk("m_ej_bid", ej_block_id, ej_m[0].bid);
                end
                xi = inj_req && e_ia;
                xn = net_in_req && e_na;
                p_ej = ej_m.size() != 0 && ej_ack;
                p_inj = inj_m.size() != 0 && net_out_ack;
            end
            @(posedge clk);
            if (!rst_n) begin
                ej_m.delete();
                inj_m.delete();
                net_prio = 1'b1;
                mis_m = 0;
            end else begin
                if (p_ej) void'(ej_m.pop_front());
                if (p_inj) void'(inj_m.pop_front());
                if (xi && inj_loc) begin
                    ej_m.push_back('{data: inj_data, instr: inj_dest_instr, slot: inj_dest_slot, bid: inj_block_id});
                    net_prio = 1'b1;
                end else if (xi) begin
                    inj_m.push_back(pack_flit(inj_dest_instr, inj_dest_slot, inj_block_id, inj_data));
                end
                if (xn && in_loc) begin
                    ej_m.push_back(unpack(net_in_flit));
                    net_prio = 1'b0;
                end else if (xn && mis_m < 255) begin
                    mis_m++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] got[$];
        int nb, nn;
        bit ia, na;
        #1 rst_n = 1'b0;
        #2;
        chk("reset_inj_ack", inj_ack, 0);
        chk("reset_net_in_ack", net_in_ack, 0);
        chk("reset_net_out_req", net_out_req, 0);
        chk("reset_ej_req", ej_req, 0);
        chk("reset_misroute", misroute_cnt, 0);
        chk("reset_ej_data", ej_data, 0);
        chk("reset_net_out_flit", net_out_flit, 0);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        tick();

        // local bypass
        inj_req = 1; inj_data = 32'hDEADBEEF; inj_dest_instr = 7'h35;
        inj_dest_slot = SLOT_RIGHT; inj_block_id = 3'd2;
        #1 chk("t1_inj_ack", inj_ack, 1);
        tick();
        inj_req = 0;
        #1;
        chk("t1_no_net_out", net_out_req, 0);
        chk("t1_ej_req", ej_req, 1);
        chk("t1_ej_data", ej_data, 32'hDEADBEEF);
        chk("t1_ej_instr", ej_dest_instr, 7'h35);
        chk("t1_ej_slot", ej_dest_slot, 1);
        chk("t1_ej_bid", ej_block_id, 2);
        ej_ack = 1;
        tick();
        ej_ack = 0;
        #1 chk("t1_ej_drained", ej_req, 0);

        // remote injection with back-pressure
        inj_dest_instr = 7'h08; inj_dest_slot = SLOT_LEFT; inj_block_id = 3'd5;
        for (int i = 0; i < 5; i++) begin
            inj_data = 32'h100 + i;
            inj_req = 1;
            #1 chk($sformatf("t2_inj_ack%0d", i), inj_ack, i < 4);
            if (i < 4) tick();
        end
        chk("t2_net_out_req", net_out_req, 1);
        net_out_ack = 1;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t2_out_req%0d", i), net_out_req, 1);
            chk($sformatf("t2_row%0d", i), net_out_flit[43:42], 0);
            chk($sformatf("t2_col%0d", i), net_out_flit[41:40], 1);
            chk($sformatf("t2_data%0d", i), net_out_flit[31:0], 32'h100 + i);
            if (i == 0) chk("t2_full_ack", inj_ack, 0);
            if (i == 1) chk("t2_refill_ack", inj_ack, 1);
            tick();
            if (i == 1) inj_req = 0;
            #1;
        end
        chk("t2_out_empty", net_out_req, 0);
        net_out_ack = 0;

        // misrouted flits
        net_in_flit = pack_flit(7'h78, SLOT_LEFT, 3'd0, 32'h55);
        net_in_req = 1;
        #1 chk("t3_ack", net_in_ack, 1);
        tick();
        #1;
        chk("t3_cnt1", misroute_cnt, 1);
        chk("t3_no_ej", ej_req, 0);
        repeat (299) tick();
        net_in_req = 0;
        #1 chk("t3_saturated", misroute_cnt, 255);

        // bypass and network contending
        ej_ack = 1; nb = 0; nn = 0;
        inj_dest_instr = 7'h35; inj_dest_slot = SLOT_PRED; inj_block_id = 3'd1;
        inj_data = 32'hB000; inj_req = 1;
        net_in_flit = pack_flit(7'h30, SLOT_LEFT, 3'd4, 32'hA000); net_in_req = 1;
        for (int c = 0; c < 14; c++) begin
            #1;
            if (ej_req) got.push_back(ej_data);
            ia = inj_req && inj_ack;
            na = net_in_req && net_in_ack;
            tick();
            if (ia) begin
                nb++;
                inj_data = 32'hB000 + nb;
                if (nb == 4) inj_req = 0;
            end
            if (na) begin
                nn++;
                net_in_flit = pack_flit(7'h30, SLOT_LEFT, 3'd4, 32'hA000 + nn);
                if (nn == 4) net_in_req = 0;
            end
        end
        chk("t4_count", got.size(), 8);
        for (int k = 0; k < 8 && k < got.size(); k++)
            chk($sformatf("t4_order%0d", k), got[k], (k % 2 == 0 ? 32'hA000 : 32'hB000) + k / 2);
        ej_ack = 0;

        // ejection FIFO full
        for (int k = 0; k < 4; k++) begin
            net_in_flit = pack_flit(7'h31, SLOT_RIGHT, 3'd6, 32'hC000 + k);
            net_in_req = 1;
            #1 chk($sformatf("t5_fill%0d", k), net_in_ack, 1);
            tick();
        end
        net_in_flit = pack_flit(7'h31, SLOT_RIGHT, 3'd6, 32'hC004);
        #1 chk("t5_full_net", net_in_ack, 0);
        inj_dest_instr = 7'h35;
        #1 chk("t5_full_byp", inj_ack, 0);
        inj_dest_instr = 7'h08; inj_data = 32'hD000; inj_block_id = 3'd0; inj_req = 1;
        #1 chk("t5_remote_ack", inj_ack, 1);
        tick();
        inj_data = 32'hD001;
        #1 chk("t5_remote_out", net_out_req, 1);

        // three entries in each FIFO, then reset
        ej_ack = 1;
        tick();
        inj_data = 32'hD002;
        tick();
        inj_req = 0; net_in_req = 0; ej_ack = 0;
        #1;
        chk("t6_pre_out", net_out_req, 1);
        chk("t6_pre_ej", ej_req, 1);
        rst_n = 0; inj_req = 1;
        net_in_flit = pack_flit(7'h31, SLOT_RIGHT, 3'd6, 32'hC005); net_in_req = 1;
        #1;
        chk("t6_inj_ack", inj_ack, 0);
        chk("t6_net_in_ack", net_in_ack, 0);
        chk("t6_net_out_req", net_out_req, 0);
        chk("t6_ej_req", ej_req, 0);
        chk("t6_misroute", misroute_cnt, 0);
        chk("t6_flit", net_out_flit, 0);
        chk("t6_ej_data", ej_data, 0);
        inj_req = 0; net_in_req = 0;
        tick();
        tick();
        #1 rst_n = 1;
        tick();
        chk("t6_post_ej", ej_req, 0);
        chk("t6_post_out", net_out_req, 0);
        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
